// File: rtl/key_sched_ctrl.sv
// AES-256 key schedule controller.
// Expands a 256-bit key into 60 words, one word per clock, using an external
// combinational S-box. Round keys are readable as soon as they are complete.
module key_sched_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         clear,
  input  logic [255:0] secret_key,
  input  logic [31:0]  sbox_out,
  output logic [31:0]  sbox_in,
  output logic         busy,
  output logic         done,
  output logic [14:0]  rk_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_data
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t      state, state_nxt;
  logic [31:0] w [0:59];
  logic [5:0]  i;
  logic [5:0]  idx_prev, idx_back8;
  logic [31:0] w_prev, w_back8, temp;
  logic [7:0]  rcon;
  logic        capture, last_word;

  // Word-store read addresses are pinned to 0 outside EXPAND so that
  // i=0 never produces an out-of-range index.
  always_comb begin
    idx_prev  = 6'd0;
    idx_back8 = 6'd0;
    if (state == EXPAND) begin
      idx_prev  = i - 6'd1;
      idx_back8 = i - 6'd8;
    end
  end

  assign w_prev  = w[idx_prev];
  assign w_back8 = w[idx_back8];

  // Round constant for the word at i (i mod 8 = 0); only Rcon[1..7] occur.
  always_comb begin
    unique case (i[5:3])
      3'd1:    rcon = 8'h01;
      3'd2:    rcon = 8'h02;
      3'd3:    rcon = 8'h04;
      3'd4:    rcon = 8'h08;
      3'd5:    rcon = 8'h10;
      3'd6:    rcon = 8'h20;
      3'd7:    rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
  end

  // S-box request and temp word: RotWord+SubWord+Rcon at i%8=0, SubWord at i%8=4.
  always_comb begin
    sbox_in = 32'h0;
    temp    = w_prev;
    if (state == EXPAND) begin
      if (i[2:0] == 3'd0) begin
        sbox_in = {w_prev[23:0], w_prev[31:24]};
        temp    = sbox_out ^ {rcon, 24'h0};
      end else if (i[2:0] == 3'd4) begin
        sbox_in = w_prev;
        temp    = sbox_out;
      end
    end
  end

  assign busy      = (state == EXPAND);
  assign capture   = (state != EXPAND) && start && !clear;
  assign last_word = (state == EXPAND) && (i == 6'd59);

  // Next-state: clear dominates; start only honoured outside EXPAND.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE, READY: if (start)     state_nxt = EXPAND;
        EXPAND:      if (last_word) state_nxt = READY;
        default:                    state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Word store, word counter, valid bits and done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i        <= 6'd0;
      done     <= 1'b0;
      rk_valid <= 15'h0;
      for (int k = 0; k < 60; k++) w[k] <= 32'h0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        i        <= 6'd0;
        rk_valid <= 15'h0;
      end else if (capture) begin
        for (int k = 0; k < 8; k++) w[k] <= secret_key[255-32*k -: 32];
        i        <= 6'd8;
        rk_valid <= 15'h0003;
      end else if (state == EXPAND) begin
        w[i] <= w_back8 ^ temp;
        i    <= i + 6'd1;
        // Writing word 4r+3 completes round key r.
        if (i[1:0] == 2'd3) rk_valid[i[5:2]] <= 1'b1;
        if (last_word)      done <= 1'b1;
      end
    end
  end

  // Round-key read port; indices beyond 14 read as zero.
  always_comb begin
    rk_data = 128'h0;
    if (rk_idx != 4'd15)
      rk_data = {w[{rk_idx, 2'b00}], w[{rk_idx, 2'b01}],
                 w[{rk_idx, 2'b10}], w[{rk_idx, 2'b11}]};
  end

endmodule
